// File: rtl/alex_pkg.sv
// Shared constants and types for the Alex LPF sequencer.
// Band edge and relay code tables are laid out for the 7-filter Alex board.
package alex_pkg;

  localparam int ALEX_NUM_FILTERS    = 7;
  localparam int ALEX_NUM_EDGES      = ALEX_NUM_FILTERS - 1;
  localparam int ALEX_HYST_HZ_DEF    = 50000;
  localparam int ALEX_BREAK_DEF      = 2048;
  localparam int ALEX_SETTLE_DEF     = 4096;

  // Ascending band edges in Hz; element 0 is the lowest edge.
  localparam logic [ALEX_NUM_EDGES-1:0][31:0] EDGE_HZ = {
    32'd32000000, 32'd22000000, 32'd15000000,
    32'd8000000,  32'd4500000,  32'd2200000
  };

  // One-hot relay drive per band; element 0 is the lowest band.
  localparam logic [ALEX_NUM_FILTERS-1:0][ALEX_NUM_FILTERS-1:0] LPF_CODE = {
    7'b0010000, 7'b0100000, 7'b1000000, 7'b0000001,
    7'b0000010, 7'b0000100, 7'b0001000
  };

  // Relay sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    SETTLE = 2'd2
  } state_e;

endpackage

// File: rtl/alex_band_hyst.sv
// Stage-1 band classifier: counts edges below the tuned frequency and
// evaluates the hysteresis windows around the currently selected band.
module alex_band_hyst
  import alex_pkg::*;
#(
  parameter int NUM_FILTERS = ALEX_NUM_FILTERS,
  parameter int FREQ_W      = 32,
  parameter int HYST_HZ     = ALEX_HYST_HZ_DEF,
  localparam int IDX_W      = $clog2(NUM_FILTERS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FREQ_W-1:0] frequency,
  input  logic [IDX_W-1:0]  cur_idx,
  output logic [IDX_W-1:0]  raw_idx,
  output logic              up_ok,
  output logic              dn_ok
);

  // One extra bit so edge+hysteresis cannot overflow.
  localparam int W1 = FREQ_W + 1;

  logic [IDX_W-1:0] raw_idx_d, raw_idx_q;
  logic             up_ok_d, up_ok_q;
  logic             dn_ok_d, dn_ok_q;
  logic [W1-1:0]    freq_ext;

  assign freq_ext = {1'b0, frequency};

  // Edge count plus up/down hysteresis tests against the current band.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    raw_idx_d = '0;
    up_ok_d   = 1'b0;
    dn_ok_d   = 1'b0;
    for (int k = 0; k < NUM_FILTERS - 1; k++) begin
      if (freq_ext > W1'(EDGE_HZ[k])) begin
        raw_idx_d = raw_idx_d + IDX_W'(1);
      end
      // Upper edge of band k; never matches the top band, so up_ok stays 0 there.
      if (IDX_W'(k) == cur_idx) begin
        up_ok_d = freq_ext > (W1'(EDGE_HZ[k]) + W1'(HYST_HZ));
      end
      // Lower edge of band k+1; never matches band 0, so dn_ok stays 0 there.
      if (IDX_W'(k + 1) == cur_idx) begin
        dn_ok_d = freq_ext <= ((W1'(EDGE_HZ[k]) >= W1'(HYST_HZ))
                               ? (W1'(EDGE_HZ[k]) - W1'(HYST_HZ)) : '0);
      end
    end
  end

  // Stage-1 register with synchronous reset.
  // NOTE: clocked state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      raw_idx_q <= '0;
      up_ok_q   <= 1'b0;
      dn_ok_q   <= 1'b0;
    end else begin
      raw_idx_q <= raw_idx_d;
      up_ok_q   <= up_ok_d;
      dn_ok_q   <= dn_ok_d;
    end
  end

  assign raw_idx = raw_idx_q;
  assign up_ok   = up_ok_q;
  assign dn_ok   = dn_ok_q;

endmodule

// File: rtl/alex_lpf_sequencer.sv
// Alex LPF relay sequencer: frequency -> band selection with hysteresis,
// then a break-before-make relay change with a settle timer, deferred by ptt.
// Optional macro ALEX_LPF_OVERRIDE_EN adds override_en/override_idx for a
// forced band selection that bypasses hysteresis but keeps the sequencing.
module alex_lpf_sequencer
  import alex_pkg::*;
#(
  parameter int NUM_FILTERS   = ALEX_NUM_FILTERS,
  parameter int FREQ_W        = 32,
  parameter int HYST_HZ       = ALEX_HYST_HZ_DEF,
  parameter int BREAK_CYCLES  = ALEX_BREAK_DEF,
  parameter int SETTLE_CYCLES = ALEX_SETTLE_DEF,
  localparam int IDX_W        = $clog2(NUM_FILTERS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [FREQ_W-1:0]      frequency,
  input  logic                   ptt,
  output logic [NUM_FILTERS-1:0] LPF,
  output logic [IDX_W-1:0]       band_idx,
  output logic                   switching,
  output logic                   tx_inhibit
`ifdef ALEX_LPF_OVERRIDE_EN
  ,
  input  logic                   override_en,
  input  logic [IDX_W-1:0]       override_idx
`endif
);

  localparam int MAX_CYC = (BREAK_CYCLES > SETTLE_CYCLES) ? BREAK_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e                 state_d, state_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic [IDX_W-1:0]       cur_d, cur_q;
  logic [IDX_W-1:0]       tgt_d, tgt_q;
  logic [NUM_FILTERS-1:0] lpf_d, lpf_q;

  logic [IDX_W-1:0] raw_idx;
  logic             up_ok;
  logic             dn_ok;
  logic [IDX_W-1:0] req_idx;
  logic             change_req;

  alex_band_hyst #(
    .NUM_FILTERS (NUM_FILTERS),
    .FREQ_W      (FREQ_W),
    .HYST_HZ     (HYST_HZ)
  ) u_band_hyst (
    .clock     (clock),
    .reset     (reset),
    .frequency (frequency),
    .cur_idx   (cur_q),
    .raw_idx   (raw_idx),
    .up_ok     (up_ok),
    .dn_ok     (dn_ok)
  );

`ifdef ALEX_LPF_OVERRIDE_EN
  // Requested band: clamped override index when forced, else hysteresis-qualified frequency band.
  always_comb begin
    req_idx    = raw_idx;
    change_req = ((raw_idx > cur_q) && up_ok) || ((raw_idx < cur_q) && dn_ok);
    if (override_en) begin
      req_idx    = (override_idx > IDX_W'(NUM_FILTERS - 1)) ? IDX_W'(NUM_FILTERS - 1)
                                                             : override_idx;
      change_req = (req_idx != cur_q);
    end
  end
`else
  // Requested band: frequency band, qualified by the hysteresis window in the move direction.
  always_comb begin
    req_idx    = raw_idx;
    change_req = ((raw_idx > cur_q) && up_ok) || ((raw_idx < cur_q) && dn_ok);
  end
`endif

  // Break-before-make sequencing: next state, counter, band and relay drive.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    lpf_d   = lpf_q;
    unique case (state_q)
      IDLE: begin
        lpf_d = NUM_FILTERS'(LPF_CODE[cur_q]);
        if (change_req && !ptt) begin
          tgt_d   = req_idx;
          lpf_d   = '0;
          cnt_d   = CNT_W'(BREAK_CYCLES - 1);
          state_d = BREAK;
        end
      end
      BREAK: begin
        if (cnt_q == '0) begin
          cur_d   = tgt_q;
          lpf_d   = NUM_FILTERS'(LPF_CODE[tgt_q]);
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state register; reset parks on band 0 with its relay closed.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      tgt_q   <= '0;
      lpf_q   <= NUM_FILTERS'(LPF_CODE[0]);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      lpf_q   <= lpf_d;
    end
  end

  assign LPF        = lpf_q;
  assign band_idx   = cur_q;
  assign switching  = (state_q != IDLE);
  assign tx_inhibit = switching;

endmodule
